rvc_fetch_aligner: RTL and testbench
====================================

Name: rvc_fetch_aligner

Overview:
- Halfword-granular realignment buffer between the instruction fetch bus and the decode stage.
- Accepts fixed-width fetch beats of FETCH_HWORDS halfwords and emits one complete RV32 instruction per handshake, either 16-bit or 32-bit.
- Handles 32-bit instructions that straddle fetch-beat boundaries and redirect targets that are not word aligned.
- Tracks the PC of each emitted instruction and flags compressed instructions so the control unit can steer the decompressor.

Parameters:
- FETCH_HWORDS, 2, halfwords per fetch beat; power of two, 2..8; the fetch bus is 16*FETCH_HWORDS bits.
- BUF_HWORDS, 6, buffer depth in halfwords; must be at least FETCH_HWORDS+2.
- RESET_PC, 32'h0000_0200, PC of the first instruction after reset.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- nRST  input  1  synchronous active-low reset.
- flush  input  1  redirect: discard all buffered parcels.
- redirect_pc  input  32  new PC, sampled when flush=1; bit 0 is ignored.
- fetch_valid  input  1  fetch beat present.
- fetch_ready  output  1  buffer can accept a full beat.
- fetch_data  input  16*FETCH_HWORDS  beat; halfword 0 is the lowest address, in the low bits.
- out_valid  output  1  a complete instruction is at the head.
- out_ready  input  1  decode consumes the head instruction.
- out_inst  output  32  instruction bits; a compressed instruction is zero-extended in bits 31:16.
- out_is_c  output  1  head instruction is 16-bit (c_ena for the decompressor and control unit).
- out_pc  output  32  PC of the head instruction.

Behaviour:
- State: halfword storage, count (0..BUF_HWORDS), head/tail pointers, pc register, skip register (0..FETCH_HWORDS-1).
- Reset, when nRST=0 at an edge:
  - count=0, pointers=0, pc=RESET_PC, skip=0, storage cleared.
  - While nRST=0, fetch_ready=0 and out_valid=0.
- fetch_ready = (count + FETCH_HWORDS <= BUF_HWORDS), computed from registered count only (no same-cycle pop credit).
- Push: on fetch_valid && fetch_ready && !flush:
  - Write halfwords skip..FETCH_HWORDS-1 in ascending order; count += FETCH_HWORDS - skip.
  - Then skip=0.
- Head decode, with h0 = head halfword and h1 = next halfword:
  - is_c = (h0[1:0] != 2'b11).
  - out_valid = (count>=1 && is_c) || (count>=2).
  - A 32-bit instruction with only one halfword buffered holds out_valid=0 until its upper half arrives.
  - out_inst = is_c ? {16'h0,h0} : {h1,h0}.
  - out_inst, out_is_c and out_pc are driven to 0 whenever out_valid=0.
- Pop: on out_valid && out_ready, remove 1 halfword (is_c) or 2; pc += 2 or 4, modulo 2^32.
- Simultaneous push and pop: both take effect; count_next = count + pushed - popped.
- Pointers wrap modulo BUF_HWORDS; non-power-of-two depth must wrap correctly.
- Flush has priority over push and pop in the same cycle; that fetch beat and pop are dropped. On flush:
  - count=0, pc={redirect_pc[31:1],1'b0}.
  - skip = redirect_pc[log2(FETCH_HWORDS):1].
  - out_valid is 0 in the following cycle.
- Fetch beats are assumed to arrive aligned to 2*FETCH_HWORDS bytes; skip drops the leading halfwords below the redirect target.
- Reset asserted mid-stream has the same effect as power-on reset; pending beats are discarded.
- No combinational path from out_ready to fetch_ready. A combinational path from fetch_valid to out_valid is forbidden; data is visible at the head one cycle after push.

Optional Feature:
- Macro: RVC_ALIGNER_C_EXT_EN.
- Defined: behaviour as above, with 16-bit instructions supported.
- Undefined:
  - is_c is forced to 0; every instruction consumes 2 halfwords and pc += 4.
  - out_valid = (count>=2); out_is_c tied to 0.
  - redirect_pc[1] is ignored (treated as 0), so skip counts whole words only.
  - Storage and count may be implemented at word granularity.

Test Plan:
- Reset, no flush, FETCH_HWORDS=2:
  - Stimulus: beats 32'h00A0_0093 and 32'h0010_8113.
  - Response: out_inst 32'h00A00093 at pc 0x200, then 32'h00108113 at pc 0x204; out_is_c=0 both.
- Mixed stream:
  - Stimulus: beat {16'h0013? no — beat {h1=16'h4501 (c.li), h0=16'h0505 (c.addi)}, then 32'h0000_0093.
  - Response: 0x0505 (is_c=1, pc 0x200), 0x4501 (pc 0x202), 0x00000093 (pc 0x204).
- Straddle:
  - Stimulus: beat {16'h0093, 16'h0505}, then beat {16'h1234, 16'h00A0}.
  - Response: 0x0505 at 0x200; 0x00A00093 at 0x202 becomes valid only after the second beat; 0x1234 follows, is_c=1.
- Misaligned redirect:
  - Stimulus: flush with redirect_pc=0x1002, then beat {16'h4501, 16'hFFFF}.
  - Response: low halfword dropped; first out 0x4501 at pc 0x1002.
  - A fetch beat presented in the flush cycle is ignored.
- Backpressure:
  - Stimulus: hold out_ready=0 and stream 32-bit beats.
  - Response: fetch_ready falls when count=6 (BUF_HWORDS=6); no data lost after out_ready returns; order and PCs preserved across pointer wrap.
- Option off (RVC_ALIGNER_C_EXT_EN undefined):
  - Stimulus: beat 32'h0000_4501.
  - Response: emitted as a single 32-bit instruction, out_is_c=0, pc advances by 4.

Source files
------------

// File: rtl/rvc_fetch_aligner_if.sv
// -----------------------------------------------------------------------------
// rvc_fetch_aligner_if
// Bus bundle between the fetch side / control unit and the RVC fetch aligner.
//   flush, redirect_pc         : redirect request and its target PC
//   fetch_valid/ready/data     : fetch beat handshake, FETCH_HWORDS halfwords,
//                                halfword 0 (lowest address) in the low bits
//   out_valid/ready            : instruction handshake towards decode
//   out_inst, out_is_c, out_pc : head instruction, compressed flag and its PC
// Modports: master = fetch/decode environment, slave = the aligner.
// -----------------------------------------------------------------------------
interface rvc_fetch_aligner_if #(
  parameter int FETCH_HWORDS = 2
);
  logic                      flush;
  logic [31:0]               redirect_pc;
  logic                      fetch_valid;
  logic                      fetch_ready;
  logic [16*FETCH_HWORDS-1:0] fetch_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [31:0]               out_inst;
  logic                      out_is_c;
  logic [31:0]               out_pc;

  modport master (
    output flush, redirect_pc, fetch_valid, fetch_data, out_ready,
    input  fetch_ready, out_valid, out_inst, out_is_c, out_pc
  );

  modport slave (
    input  flush, redirect_pc, fetch_valid, fetch_data, out_ready,
    output fetch_ready, out_valid, out_inst, out_is_c, out_pc
  );
endinterface

// File: rtl/rvc_fetch_aligner.sv
// -----------------------------------------------------------------------------
// rvc_fetch_aligner
// Halfword-granular realignment buffer between the instruction fetch bus and
// decode. Accepts beats of FETCH_HWORDS halfwords and presents one complete
// RV32 instruction (16-bit or 32-bit) at a time, with its PC.
//
// Ports:
//   CLK   : clock, all state updates on the rising edge
//   nRST  : synchronous active-low reset
//   bus   : rvc_fetch_aligner_if.slave (fetch beat input, redirect, head
//           instruction output)
//
// Configuration macro:
//   RVC_ALIGNER_C_EXT_EN : when defined, 16-bit compressed instructions are
//   recognised. When undefined every instruction is 32 bits, out_is_c is 0 and
//   redirect targets are treated as word aligned.
//
// All outputs come from flops loaded with the decode of the next buffer state,
// so there is no combinational path from any bus input to any bus output.
// Outputs are additionally forced low while nRST is asserted.
// -----------------------------------------------------------------------------
module rvc_fetch_aligner #(
  parameter int          FETCH_HWORDS = 2,
  parameter int          BUF_HWORDS   = 6,
  parameter logic [31:0] RESET_PC     = 32'h0000_0200
) (
  input  logic                CLK,
  input  logic                nRST,
  rvc_fetch_aligner_if.slave  bus
);

  localparam int PTR_W  = $clog2(BUF_HWORDS);
  localparam int CNT_W  = $clog2(BUF_HWORDS + FETCH_HWORDS + 1);
  localparam int SKIP_W = $clog2(FETCH_HWORDS);

  // Advance a buffer pointer by n halfwords, wrapping at BUF_HWORDS even when
  // the depth is not a power of two.
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] ptr,
                                               input logic [1:0]       n);
    logic [PTR_W:0] sum;
    sum = {1'b0, ptr} + {{(PTR_W-1){1'b0}}, n};
    if (sum >= (PTR_W+1)'(BUF_HWORDS)) begin
      ptr_add = PTR_W'(sum - (PTR_W+1)'(BUF_HWORDS));
    end else begin
      ptr_add = sum[PTR_W-1:0];
    end
  endfunction

  // Registered state
  logic [15:0]       mem_r [BUF_HWORDS];
  logic [PTR_W-1:0]  head_r;
  logic [PTR_W-1:0]  tail_r;
  logic [CNT_W-1:0]  count_r;
  logic [31:0]       pc_r;
  logic [SKIP_W-1:0] skip_r;
  logic              fetch_ready_r;
  logic              out_valid_r;
  logic [31:0]       out_inst_r;
  logic              out_is_c_r;
  logic [31:0]       out_pc_r;

  // Next-state signals
  logic [15:0]       mem_n_s [BUF_HWORDS];
  logic [PTR_W-1:0]  head_n_s;
  logic [PTR_W-1:0]  tail_n_s;
  logic [CNT_W-1:0]  count_n_s;
  logic [31:0]       pc_n_s;
  logic [SKIP_W-1:0] skip_n_s;
  logic [PTR_W-1:0]  wr_ptr_s;
  logic              push_s;
  logic              pop_s;
  logic [1:0]        pop_len_s;
  logic [CNT_W-1:0]  push_len_s;
  logic [SKIP_W-1:0] redirect_skip_s;
  logic [31:0]       redirect_pc_s;
  logic [15:0]       h0_n_s;
  logic [15:0]       h1_n_s;
  logic              is_c_n_s;
  logic              valid_n_s;
  logic              fetch_ready_n_s;
  logic [31:0]       inst_n_s;

  // Bit 0 of the redirect target never matters: PCs are halfword aligned.
  logic unused_s;
  assign unused_s = bus.redirect_pc[0];

  // Redirect target alignment and leading-halfword skip for the next beat.
  always_comb begin
`ifdef RVC_ALIGNER_C_EXT_EN
    redirect_pc_s   = {bus.redirect_pc[31:1], 1'b0};
    redirect_skip_s = bus.redirect_pc[SKIP_W:1];
`else
    // Without compressed support targets are word aligned: bit 1 is dropped,
    // so the skip only ever removes whole words.
    redirect_pc_s   = {bus.redirect_pc[31:2], 2'b00};
    redirect_skip_s = bus.redirect_pc[SKIP_W:1] & ~SKIP_W'(1);
`endif
  end

  // Next buffer state (flush, pop, push) and decode of the next head.
  always_comb begin
    mem_n_s    = mem_r;
    head_n_s   = head_r;
    tail_n_s   = tail_r;
    count_n_s  = count_r;
    pc_n_s     = pc_r;
    skip_n_s   = skip_r;
    wr_ptr_s   = tail_r;
    // Pops use the registered head decode, pushes the registered ready, so
    // neither handshake has a same-cycle effect on the other.
    pop_s      = out_valid_r & bus.out_ready;
    push_s     = bus.fetch_valid & fetch_ready_r;
    pop_len_s  = out_is_c_r ? 2'd1 : 2'd2;
    push_len_s = CNT_W'(FETCH_HWORDS) - CNT_W'(skip_r);

    if (bus.flush) begin
      // Redirect wins: the beat and pop of this cycle are dropped.
      head_n_s  = '0;
      tail_n_s  = '0;
      count_n_s = '0;
      pc_n_s    = redirect_pc_s;
      skip_n_s  = redirect_skip_s;
    end else begin
      if (pop_s) begin
        head_n_s = ptr_add(head_r, pop_len_s);
        pc_n_s   = pc_r + (out_is_c_r ? 32'd2 : 32'd4);
      end else begin
        head_n_s = head_r;
        pc_n_s   = pc_r;
      end

      if (push_s) begin
        // Halfwords below the redirect target are not written.
        for (int i = 0; i < FETCH_HWORDS; i++) begin
          if (i >= int'(skip_r)) begin
            mem_n_s[wr_ptr_s] = bus.fetch_data[16*i +: 16];
            wr_ptr_s          = ptr_add(wr_ptr_s, 2'd1);
          end else begin
            wr_ptr_s = wr_ptr_s;
          end
        end
        tail_n_s = wr_ptr_s;
        skip_n_s = '0;
      end else begin
        tail_n_s = tail_r;
        skip_n_s = skip_r;
      end

      count_n_s = count_r
                + (push_s ? push_len_s : CNT_W'(0))
                - (pop_s ? CNT_W'(pop_len_s) : CNT_W'(0));
    end

    h0_n_s = mem_n_s[head_n_s];
    h1_n_s = mem_n_s[ptr_add(head_n_s, 2'd1)];
`ifdef RVC_ALIGNER_C_EXT_EN
    is_c_n_s = (h0_n_s[1:0] != 2'b11);
`else
    is_c_n_s = 1'b0;
`endif
    // A 32-bit head with only its low half buffered is not yet valid.
    valid_n_s = ((count_n_s >= CNT_W'(1)) && is_c_n_s) || (count_n_s >= CNT_W'(2));
    if (valid_n_s) begin
      inst_n_s = is_c_n_s ? {16'h0000, h0_n_s} : {h1_n_s, h0_n_s};
    end else begin
      inst_n_s = 32'h0000_0000;
    end
    fetch_ready_n_s = ((count_n_s + CNT_W'(FETCH_HWORDS)) <= CNT_W'(BUF_HWORDS));
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int i = 0; i < BUF_HWORDS; i++) begin
        mem_r[i] <= 16'h0000;
      end
      head_r        <= '0;
      tail_r        <= '0;
      count_r       <= '0;
      pc_r          <= RESET_PC;
      skip_r        <= '0;
      // Empty buffer can always take a beat once reset is released.
      fetch_ready_r <= 1'b1;
      out_valid_r   <= 1'b0;
      out_inst_r    <= 32'h0000_0000;
      out_is_c_r    <= 1'b0;
      out_pc_r      <= 32'h0000_0000;
    end else begin
      mem_r         <= mem_n_s;
      head_r        <= head_n_s;
      tail_r        <= tail_n_s;
      count_r       <= count_n_s;
      pc_r          <= pc_n_s;
      skip_r        <= skip_n_s;
      fetch_ready_r <= fetch_ready_n_s;
      out_valid_r   <= valid_n_s;
      out_inst_r    <= inst_n_s;
      out_is_c_r    <= valid_n_s & is_c_n_s;
      out_pc_r      <= valid_n_s ? pc_n_s : 32'h0000_0000;
    end
  end

  assign bus.fetch_ready = nRST & fetch_ready_r;
  assign bus.out_valid   = nRST & out_valid_r;
  assign bus.out_inst    = nRST ? out_inst_r : 32'h0000_0000;
  assign bus.out_is_c    = nRST & out_is_c_r;
  assign bus.out_pc      = nRST ? out_pc_r : 32'h0000_0000;

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// -----------------------------------------------------------------------------
// tb_rvc_fetch_aligner
// Directed vector table, hand-written corner sequences and random stimulus,
// all checked against a halfword-queue reference model.
// -----------------------------------------------------------------------------
module tb_rvc_fetch_aligner;

  localparam int          FH       = 2;
  localparam int          BUF      = 6;
  localparam int          SW       = $clog2(FH);
  localparam logic [31:0] RESET_PC = 32'h0000_0200;
`ifdef RVC_ALIGNER_C_EXT_EN
  localparam bit C_EN = 1'b1;
`else
  localparam bit C_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  rvc_fetch_aligner_if #(.FETCH_HWORDS(FH)) bus ();

  rvc_fetch_aligner #(
    .FETCH_HWORDS(FH),
    .BUF_HWORDS(BUF),
    .RESET_PC(RESET_PC)
  ) dut (
    .CLK(CLK),
    .nRST(nRST),
    .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: buffered halfwords in program order, PC of the first one.
  logic [15:0] mq[$];
  logic [31:0] m_pc = RESET_PC;
  int          m_skip = 0;
  bit          m_in_rst = 1'b1;

  typedef struct {
    logic          rst;
    logic          fl;
    logic [31:0]   rpc;
    logic          fv;
    logic [16*FH-1:0] fd;
    logic          ordy;
    logic          e_ready;
    logic          e_valid;
    logic [31:0]   e_inst;
    logic          e_is_c;
    logic [31:0]   e_pc;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit m_head_c();
    return C_EN && (mq.size() > 0) && (mq[0][1:0] != 2'b11);
  endfunction

  function automatic bit m_head_valid();
    return ((mq.size() >= 1) && m_head_c()) || (mq.size() >= 2);
  endfunction

  task automatic model_step(input logic rst, input logic fl, input logic [31:0] rpc,
                            input logic fv, input logic [16*FH-1:0] fd, input logic ordy);
    bit c, v, rdy;
    c   = m_head_c();
    v   = m_head_valid();
    rdy = (mq.size() + FH) <= BUF;
    if (!rst) begin
      mq.delete();
      m_pc   = RESET_PC;
      m_skip = 0;
    end else if (fl) begin
      mq.delete();
      if (C_EN) begin
        m_pc   = {rpc[31:1], 1'b0};
        m_skip = int'(rpc[SW:1]);
      end else begin
        m_pc   = {rpc[31:2], 2'b00};
        m_skip = int'(rpc[SW:1]) & ~1;
      end
    end else begin
      if (v && ordy) begin
        if (c) begin
          void'(mq.pop_front());
          m_pc = m_pc + 32'd2;
        end else begin
          void'(mq.pop_front());
          void'(mq.pop_front());
          m_pc = m_pc + 32'd4;
        end
      end
      if (fv && rdy) begin
        for (int i = m_skip; i < FH; i++) mq.push_back(fd[16*i +: 16]);
        m_skip = 0;
      end
    end
    m_in_rst = !rst;
  endtask

  task automatic check_model();
    logic [31:0] e_inst;
    bit v, c, rdy;
    v   = m_head_valid() && !m_in_rst;
    c   = m_head_c() && v;
    rdy = ((mq.size() + FH) <= BUF) && !m_in_rst;
    e_inst = 32'h0;
    if (v) e_inst = c ? {16'h0000, mq[0]} : {mq[1], mq[0]};
    check("model_fetch_ready", 32'(bus.fetch_ready), 32'(rdy));
    check("model_out_valid",   32'(bus.out_valid),   32'(v));
    check("model_out_inst",    bus.out_inst,         e_inst);
    check("model_out_is_c",    32'(bus.out_is_c),    32'(c));
    check("model_out_pc",      bus.out_pc,           v ? m_pc : 32'h0);
  endtask

  // One clock: drive inputs, take the edge, advance the model, compare.
  task automatic cycle(input logic rst, input logic fl, input logic [31:0] rpc,
                       input logic fv, input logic [16*FH-1:0] fd, input logic ordy);
    nRST            = rst;
    bus.flush       = fl;
    bus.redirect_pc = rpc;
    bus.fetch_valid = fv;
    bus.fetch_data  = fd;
    bus.out_ready   = ordy;
    @(posedge CLK);
    model_step(rst, fl, rpc, fv, fd, ordy);
    #1;
    check_model();
  endtask

  function automatic vec_t mk(input logic rst, input logic fl, input logic [31:0] rpc,
                              input logic fv, input logic [31:0] fd, input logic ordy,
                              input logic er, input logic ev, input logic [31:0] ei,
                              input logic ec, input logic [31:0] ep);
    vec_t t;
    t.rst = rst; t.fl = fl; t.rpc = rpc; t.fv = fv; t.fd = fd; t.ordy = ordy;
    t.e_ready = er; t.e_valid = ev; t.e_inst = ei; t.e_is_c = ec; t.e_pc = ep;
    return t;
  endfunction

  initial begin
    logic [16*FH-1:0] rd;
    int valid_seen;

    bus.flush       = 1'b0;
    bus.redirect_pc = 32'h0;
    bus.fetch_valid = 1'b0;
    bus.fetch_data  = '0;
    bus.out_ready   = 1'b0;

    // Directed vectors: inputs for one edge and the outputs expected after it.
`ifdef RVC_ALIGNER_C_EXT_EN
    vecs.push_back(mk(0,0,32'h0,   0,32'h0,        0, 0,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,   0,32'h0,        0, 1,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,   1,32'h4501_0505,0, 1,1,32'h0000_0505,1,32'h200));
    vecs.push_back(mk(1,0,32'h0,   1,32'h0000_0093,1, 1,1,32'h0000_4501,1,32'h202));
    vecs.push_back(mk(1,0,32'h0,   0,32'h0,        1, 1,1,32'h0000_0093,0,32'h204));
    vecs.push_back(mk(1,0,32'h0,   0,32'h0,        1, 1,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,   1,32'h0093_0505,1, 1,1,32'h0000_0505,1,32'h208));
    vecs.push_back(mk(1,0,32'h0,   0,32'h0,        1, 1,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,   1,32'h1234_00A0,1, 1,1,32'h00A0_0093,0,32'h20A));
    vecs.push_back(mk(1,0,32'h0,   0,32'h0,        1, 1,1,32'h0000_1234,1,32'h20E));
    vecs.push_back(mk(1,0,32'h0,   0,32'h0,        1, 1,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,1,32'h1002,1,32'hDEAD_BEEF,1, 1,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,   1,32'h4501_FFFF,0, 1,1,32'h0000_4501,1,32'h1002));
    vecs.push_back(mk(1,0,32'h0,   0,32'h0,        1, 1,0,32'h0,        0,32'h0));
`else
    vecs.push_back(mk(0,0,32'h0,   0,32'h0,        0, 0,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,   0,32'h0,        0, 1,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,   1,32'h00A0_0093,0, 1,1,32'h00A0_0093,0,32'h200));
    vecs.push_back(mk(1,0,32'h0,   1,32'h0010_8113,1, 1,1,32'h0010_8113,0,32'h204));
    vecs.push_back(mk(1,0,32'h0,   0,32'h0,        1, 1,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,   1,32'h0000_4501,0, 1,1,32'h0000_4501,0,32'h208));
    vecs.push_back(mk(1,0,32'h0,   0,32'h0,        1, 1,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,   1,32'h0000_0013,0, 1,1,32'h0000_0013,0,32'h20C));
    vecs.push_back(mk(1,0,32'h0,   1,32'h0011_0093,0, 1,1,32'h0000_0013,0,32'h20C));
    vecs.push_back(mk(1,0,32'h0,   1,32'h0022_0093,0, 0,1,32'h0000_0013,0,32'h20C));
    vecs.push_back(mk(1,0,32'h0,   1,32'h0033_0093,0, 0,1,32'h0000_0013,0,32'h20C));
    vecs.push_back(mk(1,0,32'h0,   0,32'h0,        1, 1,1,32'h0011_0093,0,32'h210));
    vecs.push_back(mk(1,1,32'h1002,1,32'hDEAD_BEEF,1, 1,0,32'h0,        0,32'h0));
    vecs.push_back(mk(1,0,32'h0,   1,32'h4501_FFFF,0, 1,1,32'h4501_FFFF,0,32'h1000));
`endif

    for (int k = 0; k < vecs.size(); k++) begin
      cycle(vecs[k].rst, vecs[k].fl, vecs[k].rpc, vecs[k].fv, vecs[k].fd, vecs[k].ordy);
      check($sformatf("vec%0d_fetch_ready", k), 32'(bus.fetch_ready), 32'(vecs[k].e_ready));
      check($sformatf("vec%0d_out_valid", k),   32'(bus.out_valid),   32'(vecs[k].e_valid));
      check($sformatf("vec%0d_out_inst", k),    bus.out_inst,         vecs[k].e_inst);
      check($sformatf("vec%0d_out_is_c", k),    32'(bus.out_is_c),    32'(vecs[k].e_is_c));
      check($sformatf("vec%0d_out_pc", k),      bus.out_pc,           vecs[k].e_pc);
    end

    // Backpressure: fill with 32-bit words until ready drops, then drain.
    cycle(0, 0, 32'h0, 0, '0, 0);
    cycle(1, 0, 32'h0, 0, '0, 0);
    for (int k = 0; k < 4; k++) cycle(1, 0, 32'h0, 1, 32'h0100_0013 + 32'(k << 20), 0);
    check("bp_ready_low_when_full", 32'(bus.fetch_ready), 32'h0);
    check("bp_head_kept", bus.out_inst, 32'h0100_0013);
    valid_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (bus.out_valid) valid_seen++;
      cycle(1, 0, 32'h0, 0, '0, 1);
    end
    check("bp_drain_count", 32'(valid_seen), 32'd3);
    // Keep streaming with intermittent pops so the pointers wrap several times.
    for (int k = 0; k < 24; k++) cycle(1, 0, 32'h0, 1, 32'h0200_0093 + 32'(k << 20), 1'(k % 3 != 0));

    // Reset in the middle of a stream, with a beat on the bus.
    cycle(1, 0, 32'h0, 1, 32'h0300_0093, 0);
    cycle(0, 0, 32'h0, 1, 32'h0400_0093, 1);
    check("rst_mid_valid_low", 32'(bus.out_valid), 32'h0);
    check("rst_mid_ready_low", 32'(bus.fetch_ready), 32'h0);
    cycle(1, 0, 32'h0, 1, 32'h0500_0093, 0);
    check("rst_mid_restart_pc", bus.out_pc, RESET_PC);
    check("rst_mid_restart_inst", bus.out_inst, 32'h0500_0093);

    // Random stimulus against the model, including PC wrap at 2^32.
    for (int k = 0; k < 3000; k++) begin
      logic fl;
      logic [31:0] rpc;
      for (int h = 0; h < FH; h++) begin
        rd[16*h +: 16] = 16'($urandom);
        if ($urandom_range(1, 0) == 1) rd[16*h +: 2] = 2'b11;
      end
      fl  = ($urandom_range(29, 0) == 0);
      rpc = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15, 0))) : $urandom;
      cycle(($urandom_range(299, 0) != 0), fl, rpc,
            ($urandom_range(9, 0) < 7), rd, ($urandom_range(9, 0) < 6));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
